// File: rtl/rvga_types.sv
// Shared types for the RVGA memory-side blocks: membus arbiter state and owner encodings.
package rvga_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } membus_arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } membus_owner_t;

  localparam int unsigned wd_width = 16;

endpackage

// File: rtl/membus_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the side that did not own last.
module membus_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt
);

  assign gnt_valid = |req;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    gnt = req[1];
    if (&req) gnt = ~last;
  end

endmodule

// File: rtl/l1_membus_arbiter.sv
// Shares one DDR membus between the I-side and D-side l1cache, round-robin, with a response
// watchdog and a sticky protocol-error flag.
module l1_membus_arbiter
  import rvga_types::*;
#(
  parameter int unsigned addr_width     = 32,
  parameter int unsigned line_width     = 256,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_read_i,
  input  logic                  i_write_i,
  input  logic [addr_width-1:0] i_addr_i,
  input  logic [line_width-1:0] i_wdata_i,
  output logic                  i_resp_o,

  input  logic                  d_read_i,
  input  logic                  d_write_i,
  input  logic [addr_width-1:0] d_addr_i,
  input  logic [line_width-1:0] d_wdata_i,
  output logic                  d_resp_o,

  output logic [line_width-1:0] rdata_o,

  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [addr_width-1:0] mem_addr_o,
  output logic [line_width-1:0] mem_wdata_o,
  input  logic [line_width-1:0] mem_rdata_i,
  input  logic                  mem_resp_i,

  output logic                  timeout_o,
  output logic                  proto_err_o
);

  localparam logic [wd_width-1:0] wd_limit = wd_width'(timeout_cycles - 1);
  localparam logic [wd_width-1:0] wd_max   = '1;

  membus_arb_state_t   state;
  membus_owner_t       last_owner;
  logic                op_is_write;
  logic [wd_width-1:0] wd_cnt;
  logic                timeout_q;
  logic                proto_err_q;

  logic i_req, d_req;
  logic pick_valid, pick_gnt;
  logic win_write;
  logic granted, own_d;
  logic both_strobes;

  assign i_req        = i_read_i | i_write_i;
  assign d_req        = d_read_i | d_write_i;
  assign both_strobes = (i_read_i & i_write_i) | (d_read_i & d_write_i);

  membus_rr_pick u_pick (
    .req       ({d_req, i_req}),
    .last      (last_owner),
    .gnt_valid (pick_valid),
    .gnt       (pick_gnt)
  );

  // A simultaneous read+write counts as a write.
  assign win_write = pick_gnt ? d_write_i : i_write_i;

  // NOTE: sequential state uses non-blocking assignments; the async reset clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= OWNER_D;
      op_is_write <= 1'b0;
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (both_strobes) proto_err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            state       <= pick_gnt ? GRANT_D : GRANT_I;
            last_owner  <= membus_owner_t'(pick_gnt);
            op_is_write <= win_write;
            wd_cnt      <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_resp_i) begin
            state <= IDLE;
          end else begin
            // The watchdog only flags a stall; the transaction keeps waiting for DDR.
            if (wd_cnt == wd_limit) timeout_q <= 1'b1;
            if (wd_cnt != wd_max)   wd_cnt    <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state, so they all drop as soon as rst clears it.
  assign granted = (state == GRANT_I) || (state == GRANT_D);
  assign own_d   = (state == GRANT_D);

  assign mem_read_o  = granted & ~op_is_write;
  assign mem_write_o = granted &  op_is_write;
  assign mem_addr_o  = !granted ? '0 : (own_d ? d_addr_i  : i_addr_i);
  assign mem_wdata_o = !granted ? '0 : (own_d ? d_wdata_i : i_wdata_i);

  assign i_resp_o = (state == GRANT_I) & mem_resp_i;
  assign d_resp_o = (state == GRANT_D) & mem_resp_i;
  assign rdata_o  = granted ? mem_rdata_i : '0;

  assign timeout_o   = timeout_q;
  assign proto_err_o = proto_err_q;

endmodule
